// File: rtl/mult_arbiter_if.sv
// Bundle between mult_arbiter, its two requesters and the shared sequential
// multiplier (control unit + datapath).
interface mult_arbiter_if #(
  parameter int WIDTH = 8
);
  // Handshake: a requester raises reqN with aN/bN stable and holds it until
  // ackN pulses for one cycle; result (and err) are valid only in that cycle.
  // On the multiplier side, mul_load is a one-cycle start command with
  // mul_a/mul_b already valid; mul_done is a level that rises on completion
  // and stays high until the next mul_load, with mul_product valid while high.
  logic                   req0;
  logic                   req1;
  logic [WIDTH-1:0]       a0;
  logic [WIDTH-1:0]       b0;
  logic [WIDTH-1:0]       a1;
  logic [WIDTH-1:0]       b1;
  logic                   ack0;
  logic                   ack1;
  logic [2*WIDTH-1:0]     result;
  logic                   err;
  logic                   busy;
  logic                   mul_load;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_product;

  modport master (
    input  req0, req1, a0, b0, a1, b1, mul_done, mul_product,
    output ack0, ack1, result, err, busy, mul_load, mul_a, mul_b
  );

  modport slave (
    output req0, req1, a0, b0, a1, b1, mul_done, mul_product,
    input  ack0, ack1, result, err, busy, mul_load, mul_a, mul_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier between two
// requesters. Optional completion timeout: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  mult_arbiter_if.master bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             rr_q;
  logic             owner_q;
  logic             mul_done_q;
  logic             grant;
  logic             done_edge;
  logic             timed_out;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mult_arbiter: TIMEOUT must be at least 1");
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counts cycles spent in WAIT; zero on the first WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != WAIT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  assign state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    grant     = bus.req1;
    done_edge = bus.mul_done & ~mul_done_q;
    timed_out = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif
    if (bus.req0 && bus.req1) begin
      grant = rr_q;
    end
    sel_a = grant ? bus.a1 : bus.a0;
    sel_b = grant ? bus.b1 : bus.b0;

    case (state_q)
      IDLE: if (bus.req0 || bus.req1) state_d = LOAD;
      LOAD: state_d = WAIT;
      // A done level already high when WAIT is entered is stale: only a fresh
      // rising edge counts. An edge coinciding with expiry is a success.
      WAIT: if (done_edge || timed_out) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is registered from the next-state decision, so no
  // combinational path exists from req*/mul_done to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      mul_done_q   <= 1'b0;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.err      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.mul_load <= 1'b0;
      bus.mul_a    <= '0;
      bus.mul_b    <= '0;
      bus.result   <= '0;
    end else begin
      mul_done_q   <= bus.mul_done;
      bus.mul_load <= (state_d == LOAD);
      bus.busy     <= (state_d != IDLE);
      bus.ack0     <= (state_d == RESP) && !owner_q;
      bus.ack1     <= (state_d == RESP) && owner_q;
`ifdef MULT_ARB_TIMEOUT_EN
      bus.err      <= (state_d == RESP) && !done_edge;
`else
      bus.err      <= 1'b0;
`endif
      if (state_q == IDLE && state_d == LOAD) begin
        owner_q   <= grant;
        rr_q      <= ~grant;
        bus.mul_a <= sel_a;
        bus.mul_b <= sel_b;
      end
      if (state_d == RESP) begin
        bus.result <= done_edge ? bus.mul_product : '0;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_mult_arbiter;
  localparam int W  = 8;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  mult_arbiter_if #(.WIDTH(W)) bus ();

  mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W:0] exp_q[$];

  // ---------------- multiplier model ----------------
  // mode 0: done rises mm_lat cycles after load; 1: stale level kept one
  // cycle after load, then rises 8 cycles later; 2: never completes.
  int  mm_mode = 0;
  int  mm_lat = 10;
  int  mm_cnt = -1;
  bit  mm_drop = 0;
  bit  mm_preset = 0;
  logic signed [2*W-1:0] op_a, op_b;

  initial begin
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(negedge clk);
      if (mm_preset) begin
        mm_preset       = 0;
        bus.mul_done    = 1'b1;
        bus.mul_product = 16'h5A5A;
      end else if (bus.mul_load) begin
        op_a = $signed(bus.mul_a);
        op_b = $signed(bus.mul_b);
        if (mm_mode == 1) begin
          mm_drop = 1;
          mm_cnt  = -1;
        end else begin
          bus.mul_done = 1'b0;
          mm_cnt = (mm_mode == 2) ? -1 : mm_lat;
        end
      end else if (mm_drop) begin
        mm_drop      = 0;
        bus.mul_done = 1'b0;
        mm_cnt       = 8;
      end else if (mm_cnt > 0) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          bus.mul_done    = 1'b1;
          bus.mul_product = op_a * op_b;
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_check(input string name);
    logic [2*W:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: actual=unexpected ack required=no ack (t=%0t)", name, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, {bus.ack1, bus.result}, e);
    end
  endtask

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic do_reset(input bit chk);
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1;
    if (chk) begin
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_err", bus.err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_load", bus.mul_load, 0);
      check("rst_mul_a", bus.mul_a, 0);
      check("rst_mul_b", bus.mul_b, 0);
      check("rst_result", bus.result, 0);
      check("rst_state", state_dbg, 0);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ack(input int budget, output int who, output logic [2*W-1:0] r,
                          output logic e, output int waited);
    who = -1; r = '0; e = 1'b0; waited = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        who = bus.ack1 ? 1 : 0;
        r = bus.result;
        e = bus.err;
        waited = c;
        return;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit           r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    int           n;
    bit           own0, own1;
    logic [2*W-1:0] res0, res1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int who, waited, na, nl;
    int ack_c[4];
    int load_c[4];
    logic [2*W-1:0] r;
    logic e;

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

    tbl[0] = '{1, 0, 8'h05, 8'hFD, 8'h00, 8'h00, 1, 0, 0, 16'hFFF1, 16'h0000};
    tbl[1] = '{1, 1, 8'h07, 8'h06, 8'hFC, 8'hFC, 2, 0, 1, 16'h002A, 16'h0010};
    tbl[2] = '{0, 1, 8'h00, 8'h00, 8'h7F, 8'h80, 1, 1, 0, 16'hC080, 16'h0000};
    tbl[3] = '{1, 1, 8'h80, 8'h80, 8'hFF, 8'h01, 2, 0, 1, 16'h4000, 16'hFFFF};
    tbl[4] = '{1, 0, 8'h9C, 8'h03, 8'h00, 8'h00, 1, 0, 0, 16'hFED4, 16'h0000};

    repeat (3) @(negedge clk);
    do_reset(1);

    for (int i = 0; i < 5; i++) begin
      do_reset(0);
      mm_mode = 0; mm_lat = 10;
      bus.a0 = tbl[i].a0; bus.b0 = tbl[i].b0;
      bus.a1 = tbl[i].a1; bus.b1 = tbl[i].b1;
      bus.req0 = tbl[i].r0; bus.req1 = tbl[i].r1;
      exp_q.push_back({tbl[i].own0, tbl[i].res0});
      if (tbl[i].n == 2) exp_q.push_back({tbl[i].own1, tbl[i].res1});
      na = 0; nl = 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (bus.mul_load) begin
          if (nl < 4) load_c[nl] = c;
          nl++;
        end
        if (bus.ack0 || bus.ack1) begin
          if (na < 4) ack_c[na] = c;
          na++;
          sb_check("tbl_result");
          check("tbl_err", bus.err, 0);
          if (bus.ack0) bus.req0 = 1'b0;
          if (bus.ack1) bus.req1 = 1'b0;
        end
      end
      check("tbl_nack", na, tbl[i].n);
      check("tbl_nload", nl, tbl[i].n);
      if (nl >= 1) check("tbl_load_lat", load_c[0], 0);
      for (int k = 0; k < tbl[i].n && k < na && k < nl; k++)
        check("tbl_ack_lat", ack_c[k] - load_c[k], 11);
      if (tbl[i].n == 2 && na >= 1 && nl >= 2)
        check("tbl_regrant", load_c[1] - ack_c[0], 2);
      check("tbl_sb_empty", exp_q.size(), 0);
      exp_q.delete();
    end

    // ---- stale done level held through LOAD ----
    do_reset(0);
    mm_mode = 1; mm_preset = 1;
    repeat (2) tick();
    bus.a0 = 8'h0B; bus.b0 = 8'hF6; bus.req0 = 1'b1;
    na = 0; nl = 0; ack_c[0] = -1; load_c[0] = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.mul_load) begin
        if (nl == 0) load_c[0] = c;
        nl++;
      end
      if (bus.ack0 || bus.ack1) begin
        if (na == 0) begin
          ack_c[0] = c;
          check("stale_owner", bus.ack1, 0);
          check("stale_result", bus.result, 16'hFF92);
        end
        na++;
        bus.req0 = 1'b0;
      end
    end
    check("stale_nack", na, 1);
    check("stale_lat", ack_c[0] - load_c[0], 10);

    // ---- reset in the middle of WAIT ----
    do_reset(0);
    mm_mode = 0; mm_lat = 10;
    bus.a0 = 8'h03; bus.b0 = 8'h03; bus.req0 = 1'b1;
    wait_ack(30, who, r, e, waited);
    check("mid_first_owner", who, 0);
    check("mid_first_result", r, 16'h0009);
    bus.req0 = 1'b0;
    tick();
    bus.a0 = 8'h02; bus.b0 = 8'h02; bus.req0 = 1'b1;
    repeat (6) tick();
    check("mid_busy_before", bus.busy, 1);
    bus.req0 = 1'b0;
    bus.a1 = 8'hFB; bus.b1 = 8'h05; bus.req1 = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_mul_a", bus.mul_a, 0);
    check("mid_rst_mul_b", bus.mul_b, 0);
    check("mid_rst_acks", {bus.ack0, bus.ack1, bus.err, bus.mul_load}, 0);
    check("mid_rst_state", state_dbg, 0);
    tick();
    rst = 1'b0;
    wait_ack(30, who, r, e, waited);
    check("mid_next_owner", who, 1);
    check("mid_next_result", r, 16'hFFE7);
    bus.req1 = 1'b0;

    // ---- multiplier that never completes ----
    do_reset(0);
    mm_mode = 0; mm_lat = 5;
    bus.a1 = 8'h03; bus.b1 = 8'h04; bus.req1 = 1'b1;
    wait_ack(30, who, r, e, waited);
    check("to_pre_result", r, 16'h000C);
    bus.req1 = 1'b0;
    repeat (2) tick();
    mm_mode = 2;
    bus.req1 = 1'b1;
    tick();
    check("to_load", bus.mul_load, 1);
`ifdef MULT_ARB_TIMEOUT_EN
    wait_ack(40, who, r, e, waited);
    check("to_owner", who, 1);
    check("to_wait", waited, TO);
    check("to_err", e, 1);
    check("to_result", r, 0);
    bus.req1 = 1'b0;
    tick();
    check("to_err_pulse", bus.err, 0);
`else
    for (int c = 0; c < 200; c++) begin
      tick();
      check("hang_busy", bus.busy, 1);
      check("hang_acks", {bus.ack0, bus.ack1, bus.err}, 0);
    end
`endif
    do_reset(0);

    // ---- randomized run against reference model ----
    begin
      int m_free, m_rr, m_owner, m_load, m_ack, idle0, idle1;
      bit m_busy, r0, r1;
      m_free = 0; m_rr = 0; m_owner = 0; m_load = -1; m_ack = -1; m_busy = 0;
      idle0 = 0; idle1 = 3;
      mm_mode = 0;
      exp_q.delete();
      for (int ev = 0; ev < 3000; ev++) begin
        tick();
        r0 = bus.req0; r1 = bus.req1;
        if (!m_busy && ev >= m_free && (r0 || r1)) begin
          m_owner = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
          m_rr    = 1 - m_owner;
          mm_lat  = $urandom_range(1, 12);
          m_load  = ev;
          m_ack   = ev + mm_lat + 1;
          m_busy  = 1;
          exp_q.push_back({m_owner[0], m_owner ? prod(bus.a1, bus.b1) : prod(bus.a0, bus.b0)});
        end
        check("rnd_load", bus.mul_load, m_busy && ev == m_load);
        check("rnd_busy", bus.busy, m_busy);
        check("rnd_ack0", bus.ack0, m_busy && ev == m_ack && m_owner == 0);
        check("rnd_ack1", bus.ack1, m_busy && ev == m_ack && m_owner == 1);
        if (bus.ack0 || bus.ack1) begin
          sb_check("rnd_result");
          check("rnd_err", bus.err, 0);
        end
        if (m_busy && ev == m_ack) begin
          m_busy = 0;
          m_free = ev + 2;
        end
        if (bus.ack0 || (bus.req0 && $urandom_range(0, 31) == 0)) begin
          bus.req0 = 1'b0; idle0 = $urandom_range(0, 6);
        end else if (!bus.req0) begin
          if (idle0 == 0) begin
            bus.req0 = 1'b1; bus.a0 = W'($urandom); bus.b0 = W'($urandom);
          end else idle0--;
        end
        if (bus.ack1 || (bus.req1 && $urandom_range(0, 31) == 0)) begin
          bus.req1 = 1'b0; idle1 = $urandom_range(0, 6);
        end else if (!bus.req1) begin
          if (idle1 == 0) begin
            bus.req1 = 1'b1; bus.a1 = W'($urandom); bus.b1 = W'($urandom);
          end else idle1--;
        end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      for (int c = 0; c < 20 && m_busy; c++) begin
        tick();
        if (bus.ack0 || bus.ack1) begin
          sb_check("rnd_drain");
          m_busy = 0;
        end
      end
      check("rnd_sb_empty", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
